if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction-fetch stage of the pipelined core. It sits directly upstream of the IF/ID pipeline register and owns the program counter. It fetches from a variable-latency instruction memory (cache or backing memory) over a request/ready handshake. Each cycle it presents either a valid `{PC+4, instruction}` pair or a NOP bubble (all zeros) to the IF/ID register, and it honours hazard freeze and branch redirect.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address loaded on reset.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-low reset (sampled on rising `clk`; `rst`=0 resets).
- `freeze`  in  1: hazard stall from the hazard unit; hold the current fetch and do not advance the PC.
- `branch_taken`  in  1: redirect from the EX stage; also squashes this cycle's output.
- `branch_addr`  in  32: redirect target, valid when `branch_taken`=1.
- `imem_req`  out  1: fetch request to the instruction memory.
- `imem_addr`  out  32: fetch address; equals the `pc` register.
- `imem_ready`  in  1: memory has returned `imem_rdata` for the current request; may assert in the same cycle as `imem_req`.
- `imem_rdata`  in  32: instruction word, valid when `imem_ready`=1.
- `pc_out`  out  32: fetched address + 4, or 0 when bubbling; feeds the IF/ID PC input.
- `instruction_out`  out  32: fetched instruction, or 0 (NOP) when bubbling.
- `inst_valid`  out  1: `pc_out` and `instruction_out` carry a real instruction.

## Operation
- Registers:
  - `pc` (32)
  - `state` (FETCH / HOLD / DRAIN)
  - `hold_buf` (32)
  - `redirect_pc` (32)
- Memory protocol:
  - One request outstanding at a time.
  - `imem_req` and `imem_addr` stay stable from assertion until the cycle `imem_ready`=1.
  - A request is never withdrawn before `imem_ready`.
- FETCH state:
  - `imem_req`=1.
  - `imem_ready` & `branch_taken`: discard the data, `pc`<=`branch_addr`, stay in FETCH, output a bubble.
  - `~imem_ready` & `branch_taken`: `redirect_pc`<=`branch_addr`, go to DRAIN, output a bubble.
  - `imem_ready` & `~branch_taken` & `~freeze`: output `{pc+4, imem_rdata}` combinationally with `inst_valid`=1, `pc`<=`pc+4`, stay in FETCH.
  - `imem_ready` & `~branch_taken` & `freeze`: `hold_buf`<=`imem_rdata`, go to HOLD. Outputs show the valid instruction; the downstream register is frozen, so this is harmless.
  - `~imem_ready` & `~branch_taken`: bubble, stay in FETCH; `freeze` has no effect.
- HOLD state:
  - `imem_req`=0.
  - Outputs are `{pc+4, hold_buf}` with `inst_valid`=1.
  - `branch_taken`: `pc`<=`branch_addr`, go to FETCH, output a bubble.
  - Else if `~freeze`: `pc`<=`pc+4`, go to FETCH. The held instruction is consumed this cycle.
  - Else stay in HOLD.
- DRAIN state:
  - `imem_req`=1 with the old `pc`, waiting out the abandoned request. Output is a bubble.
  - A further `branch_taken` overwrites `redirect_pc` with the newest `branch_addr`.
  - On `imem_ready`: discard the data. `pc`<=the newest redirect target, which is `branch_addr` if `branch_taken`=1 in this same cycle, else `redirect_pc`. Go to FETCH.
- Priority: `rst` > `branch_taken` > `freeze`.
- Arithmetic: `pc+4` is a 32-bit modulo add; 32'hFFFF_FFFC + 4 wraps to 0. `branch_addr` is used unmodified, with no alignment check.
- Bubble encoding: `pc_out`=0, `instruction_out`=0, `inst_valid`=0.

## Timing
- Reset (`rst`=0 at an edge):
  - `pc`<=`RESET_PC`, `state`<=FETCH, `hold_buf`<=0, `redirect_pc`<=0.
  - While `rst`=0: `imem_req`=0 and outputs are bubble (forced combinationally).
  - First request is issued in the first cycle after `rst` returns to 1.
- Reset mid-DRAIN or mid-request abandons the transaction. The memory is reset by the same `rst`.
- Zero-wait memory (`imem_ready` same cycle): one instruction per cycle and no bubbles.
- N-wait memory: N bubble cycles, then a valid instruction.
- Outputs are combinational from `state`, `pc`, `hold_buf`, `imem_ready`, `imem_rdata` and `branch_taken`. They are captured by the IF/ID register on the same edge.
- Branch penalty:
  - The redirect target is requested in the cycle after `branch_taken` in FETCH/HOLD.
  - In DRAIN, the target is requested in the cycle after the old request's `imem_ready`.

## Test plan
- Reset and zero-wait stream:
  - Stimulus: hold `rst`=0 for 2 cycles, then release. Memory returns `imem_ready`=1 every cycle with `rdata` = addr ^ 32'hA5A5_0000.
  - Required response: while `rst`=0, `imem_req`=0 and outputs are 0. From the first cycle after release, `imem_addr` = 0, 4, 8 in consecutive cycles and `pc_out` = 4, 8, 12 with `inst_valid`=1.
- Wait states:
  - Stimulus: ready asserted 3 cycles after each request.
  - Required response: 3 bubble cycles per instruction. `imem_addr` stays stable until ready. `pc_out`=addr+4 only in the ready cycle.
- Freeze:
  - Stimulus: `freeze`=1 for 4 cycles, starting in a cycle with `imem_ready`=1 at addr 0x10 (data 0xE3A0_1005).
  - Required response: enter HOLD with outputs fixed at {0x14, 0xE3A0_1005} and `imem_req`=0. On release, the next request is at 0x14.
- Branch while request outstanding:
  - Stimulus: in a wait-state memory, assert `branch_taken` at addr 0x20 before ready, with target 0x100. Then assert `branch_taken` again in DRAIN with target 0x200.
  - Required response: the old data is discarded, outputs are bubbles, and the next `imem_addr` after ready is 0x200.
- Branch plus freeze in the same cycle during HOLD:
  - Stimulus: assert `branch_taken` and `freeze` together while in HOLD.
  - Required response: the branch wins; the next request is at `branch_addr` and the output is a bubble that cycle.
- PC wrap:
  - Stimulus: set `RESET_PC`=32'hFFFF_FFFC with zero-wait memory.
  - Required response: `pc_out`=0, and the next `imem_addr`=0.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC and fetches from a variable-latency memory.
// Each cycle it presents either a valid {PC+4, instruction} pair or a NOP bubble to IF/ID.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_freeze,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_addr,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ready,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_pc_out,
    output logic [31:0] o_instruction_out,
    output logic        o_inst_valid
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_hold_buf;
    logic [31:0] r_redirect_pc;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_hold_buf_nxt;
    logic [31:0] w_redirect_pc_nxt;
    logic [31:0] w_pc_plus4;

    assign w_pc_plus4  = r_pc + 32'd4;
    assign o_imem_addr = r_pc;

    // State register with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state       <= ST_FETCH;
            r_pc          <= RESET_PC;
            r_hold_buf    <= 32'h0000_0000;
            r_redirect_pc <= 32'h0000_0000;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_hold_buf    <= w_hold_buf_nxt;
            r_redirect_pc <= w_redirect_pc_nxt;
        end
    end

    // Next-state and output logic; the branch always outranks freeze.
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_hold_buf_nxt    = r_hold_buf;
        w_redirect_pc_nxt = r_redirect_pc;
        o_imem_req        = 1'b0;
        o_pc_out          = 32'h0000_0000;
        o_instruction_out = 32'h0000_0000;
        o_inst_valid      = 1'b0;

        case (r_state)
            ST_FETCH: begin
                o_imem_req = 1'b1;
                if (i_branch_taken) begin
                    if (i_imem_ready) begin
                        w_pc_nxt = i_branch_addr;
                    end else begin
                        // Request cannot be withdrawn, so park the target until it completes.
                        w_redirect_pc_nxt = i_branch_addr;
                        w_state_nxt       = ST_DRAIN;
                    end
                end else if (i_imem_ready) begin
                    o_pc_out          = w_pc_plus4;
                    o_instruction_out = i_imem_rdata;
                    o_inst_valid      = 1'b1;
                    if (i_freeze) begin
                        w_hold_buf_nxt = i_imem_rdata;
                        w_state_nxt    = ST_HOLD;
                    end else begin
                        w_pc_nxt = w_pc_plus4;
                    end
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (i_branch_taken) begin
                    w_pc_nxt    = i_branch_addr;
                    w_state_nxt = ST_FETCH;
                end else begin
                    o_pc_out          = w_pc_plus4;
                    o_instruction_out = r_hold_buf;
                    o_inst_valid      = 1'b1;
                    if (!i_freeze) begin
                        w_pc_nxt    = w_pc_plus4;
                        w_state_nxt = ST_FETCH;
                    end else begin
                        w_state_nxt = ST_HOLD;
                    end
                end
            end
            ST_DRAIN: begin
                o_imem_req = 1'b1;
                if (i_branch_taken) begin
                    w_redirect_pc_nxt = i_branch_addr;
                end else begin
                    w_redirect_pc_nxt = r_redirect_pc;
                end
                if (i_imem_ready) begin
                    w_pc_nxt    = i_branch_taken ? i_branch_addr : r_redirect_pc;
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase

        // Held in reset: no request and a bubble on the outputs.
        if (!i_rst) begin
            o_imem_req        = 1'b0;
            o_pc_out          = 32'h0000_0000;
            o_instruction_out = 32'h0000_0000;
            o_inst_valid      = 1'b0;
        end else begin
            o_imem_req = o_imem_req;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: reset, zero-wait stream, wait states, freeze,
// branch during an outstanding request, branch+freeze in HOLD, and PC wrap.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic        inst_valid;

    logic        w_freeze;
    logic        w_branch;
    logic [31:0] w_baddr;
    logic        w_ready;
    logic [31:0] w_rdata;
    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_pc_out;
    logic [31:0] w_instr;
    logic        w_valid;

    int n_checks = 0;
    int n_errors = 0;

    if_fetch_unit dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_freeze          (freeze),
        .i_branch_taken    (branch_taken),
        .i_branch_addr     (branch_addr),
        .o_imem_req        (imem_req),
        .o_imem_addr       (imem_addr),
        .i_imem_ready      (imem_ready),
        .i_imem_rdata      (imem_rdata),
        .o_pc_out          (pc_out),
        .o_instruction_out (instruction_out),
        .o_inst_valid      (inst_valid)
    );

    // Second instance with a wrapping reset PC and a zero-wait memory.
    assign w_freeze = 1'b0;
    assign w_branch = 1'b0;
    assign w_baddr  = 32'h0000_0000;
    assign w_ready  = 1'b1;
    assign w_rdata  = w_addr ^ 32'hA5A5_0000;

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_freeze          (w_freeze),
        .i_branch_taken    (w_branch),
        .i_branch_addr     (w_baddr),
        .o_imem_req        (w_req),
        .o_imem_addr       (w_addr),
        .i_imem_ready      (w_ready),
        .i_imem_rdata      (w_rdata),
        .o_pc_out          (w_pc_out),
        .o_instruction_out (w_instr),
        .o_inst_valid      (w_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply inputs mid-cycle (negedge), then let combinational outputs settle.
    task automatic drive(input logic r, input logic rdy, input logic [31:0] rd,
                         input logic br, input logic [31:0] ba, input logic fz);
        @(negedge clk);
        rst          = r;
        imem_ready   = rdy;
        imem_rdata   = rd;
        branch_taken = br;
        branch_addr  = ba;
        freeze       = fz;
        #1;
    endtask

    task automatic out(input string tag, input logic req, input logic [31:0] addr,
                       input logic [31:0] pc, input logic [31:0] ins, input logic v);
        chk({tag, ".req"},   {31'd0, imem_req},   {31'd0, req});
        chk({tag, ".addr"},  imem_addr,           addr);
        chk({tag, ".pc"},    pc_out,              pc);
        chk({tag, ".instr"}, instruction_out,     ins);
        chk({tag, ".valid"}, {31'd0, inst_valid}, {31'd0, v});
    endtask

    initial begin
        rst = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0; branch_taken = 1'b0;
        branch_addr = 32'h0; freeze = 1'b0;

        // Reset held for two cycles
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 32'h1234_5678, 1'b0, 32'h0, 1'b0);
            chk("rst.req",   {31'd0, imem_req},   32'd0);
            chk("rst.pc",    pc_out,              32'd0);
            chk("rst.instr", instruction_out,     32'd0);
            chk("rst.valid", {31'd0, inst_valid}, 32'd0);
            chk("rst.wreq",  {31'd0, w_req},      32'd0);
        end

        // Zero-wait stream from address 0
        drive(1'b1, 1'b1, 32'hA5A5_0000, 1'b0, 32'h0, 1'b0);
        out("zw0", 1'b1, 32'h0, 32'h4, 32'hA5A5_0000, 1'b1);
        chk("wrap.addr0",  w_addr,   32'hFFFF_FFFC);
        chk("wrap.pc0",    w_pc_out, 32'h0000_0000);
        chk("wrap.instr0", w_instr,  32'h5A5A_FFFC);
        chk("wrap.valid0", {31'd0, w_valid}, 32'd1);
        drive(1'b1, 1'b1, 32'hA5A5_0004, 1'b0, 32'h0, 1'b0);
        out("zw1", 1'b1, 32'h4, 32'h8, 32'hA5A5_0004, 1'b1);
        chk("wrap.addr1",  w_addr,   32'h0000_0000);
        chk("wrap.pc1",    w_pc_out, 32'h0000_0004);
        drive(1'b1, 1'b1, 32'hA5A5_0008, 1'b0, 32'h0, 1'b0);
        out("zw2", 1'b1, 32'h8, 32'hC, 32'hA5A5_0008, 1'b1);

        // Three wait states at 0xC
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0);
            out("wait", 1'b1, 32'hC, 32'h0, 32'h0, 1'b0);
        end
        drive(1'b1, 1'b1, 32'h1111_0000, 1'b0, 32'h0, 1'b0);
        out("wait.rdy", 1'b1, 32'hC, 32'h10, 32'h1111_0000, 1'b1);

        // Freeze for four cycles starting at ready for 0x10
        drive(1'b1, 1'b1, 32'hE3A0_1005, 1'b0, 32'h0, 1'b1);
        out("frz0", 1'b1, 32'h10, 32'h14, 32'hE3A0_1005, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
            out("hold", 1'b0, 32'h10, 32'h14, 32'hE3A0_1005, 1'b1);
        end
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        out("hold.rel", 1'b0, 32'h10, 32'h14, 32'hE3A0_1005, 1'b1);
        drive(1'b1, 1'b1, 32'hA5A5_0014, 1'b0, 32'h0, 1'b0);
        out("post.frz", 1'b1, 32'h14, 32'h18, 32'hA5A5_0014, 1'b1);
        drive(1'b1, 1'b1, 32'hA5A5_0018, 1'b0, 32'h0, 1'b0);
        out("s18", 1'b1, 32'h18, 32'h1C, 32'hA5A5_0018, 1'b1);
        drive(1'b1, 1'b1, 32'hA5A5_001C, 1'b0, 32'h0, 1'b0);
        out("s1c", 1'b1, 32'h1C, 32'h20, 32'hA5A5_001C, 1'b1);

        // Branch at 0x20 before ready, then re-branch in DRAIN
        drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0);
        out("br.out", 1'b1, 32'h20, 32'h0, 32'h0, 1'b0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        out("drain0", 1'b1, 32'h20, 32'h0, 32'h0, 1'b0);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0);
        out("drain.br", 1'b1, 32'h20, 32'h0, 32'h0, 1'b0);
        drive(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
        out("drain.rdy", 1'b1, 32'h20, 32'h0, 32'h0, 1'b0);

        // Fetch at redirected 0x200 with freeze, then branch+freeze in HOLD
        drive(1'b1, 1'b1, 32'h1234_5678, 1'b0, 32'h0, 1'b1);
        out("f200", 1'b1, 32'h200, 32'h204, 32'h1234_5678, 1'b1);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h300, 1'b1);
        out("hold.brfz", 1'b0, 32'h200, 32'h0, 32'h0, 1'b0);
        drive(1'b1, 1'b1, 32'hAAAA_5555, 1'b0, 32'h0, 1'b0);
        out("f300", 1'b1, 32'h300, 32'h304, 32'hAAAA_5555, 1'b1);

        // Branch in FETCH with data ready: data discarded
        drive(1'b1, 1'b1, 32'hBBBB_BBBB, 1'b1, 32'h40, 1'b0);
        out("fetch.brrdy", 1'b1, 32'h304, 32'h0, 32'h0, 1'b0);
        // Into DRAIN, then ready and newer branch in the same cycle
        drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h50, 1'b0);
        out("f40.br", 1'b1, 32'h40, 32'h0, 32'h0, 1'b0);
        drive(1'b1, 1'b1, 32'hCCCC_CCCC, 1'b1, 32'h60, 1'b0);
        out("drain.rdybr", 1'b1, 32'h40, 32'h0, 32'h0, 1'b0);
        drive(1'b1, 1'b1, 32'h0000_0013, 1'b0, 32'h0, 1'b0);
        out("f60", 1'b1, 32'h60, 32'h64, 32'h0000_0013, 1'b1);

        // Reset reasserted mid-stream
        drive(1'b0, 1'b1, 32'h0000_0013, 1'b0, 32'h0, 1'b0);
        chk("rst2.req",   {31'd0, imem_req},   32'd0);
        chk("rst2.valid", {31'd0, inst_valid}, 32'd0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        out("rst2.fetch", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
